ram_wr_sched: RTL and testbench

RAM_WR_SCHED -- requirements
Module: ram_wr_sched

---
 rtl/ram_ctrl_pkg.sv | 14 +
 rtl/ram_rr_pick.sv | 33 +++
 rtl/ram_wr_sched.sv | 150 +++++++++++++++
 tb/tb_ram_wr_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM write scheduler.
package ram_ctrl_pkg;

    // Scheduler modes: arbitrating requester writes, or filling the whole RAM.
    typedef enum logic {
        ARB  = 1'b0,
        INIT = 1'b1
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int NUM_REQ_DEF    = 4;

endpackage

// File: rtl/ram_rr_pick.sv
// Round-robin picker: first set request at or above ptr_i, wrapping upward.
module ram_rr_pick
    import ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_onehot_o,
    output logic [PTR_W-1:0]   win_idx_o,
    output logic               win_vld_o
);

    logic [PTR_W-1:0] pos;

    // Walk the requesters starting at the pointer; the first set bit wins.
    always_comb begin
        win_onehot_o = '0;
        win_idx_o    = '0;
        win_vld_o    = 1'b0;
        pos          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!win_vld_o && req_i[pos]) begin
                win_vld_o         = 1'b1;
                win_onehot_o[pos] = 1'b1;
                win_idx_o         = pos;
            end
        end
    end

endmodule

// File: rtl/ram_wr_sched.sv
// RAM write-port scheduler: round-robin requester writes plus a full-memory fill.
module ram_wr_sched
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF
) (
    input  logic                          clk_w,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          init_start,
    input  logic [DATA_WIDTH-1:0]         init_value,
    output logic                          busy,
    output logic                          init_done,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_in
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Counter is one bit wider than the address so the last-address compare never aliases.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'((2**ADDR_WIDTH) - 1);

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      mask_q, mask_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   fill_q, fill_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [NUM_REQ-1:0]      win_onehot;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_vld;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;

    // The requester granted last cycle is masked so a lingering req cannot write twice.
    ram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i        (req & ~mask_q),
        .ptr_i        (rr_ptr_q),
        .win_onehot_o (win_onehot),
        .win_idx_o    (win_idx),
        .win_vld_o    (win_vld)
    );

    // Route the winning requester's address and data slices.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and output-register logic for the ARB/INIT controller.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        mask_d   = '0;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        gnt_d    = '0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            ARB: begin
                if (init_start) begin
                    state_d = INIT;
                    fill_d  = init_value;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (win_vld) begin
                    gnt_d    = win_onehot;
                    we_d     = 1'b1;
                    addr_d   = sel_addr;
                    data_d   = sel_data;
                    mask_d   = win_onehot;
                    rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end
            INIT: begin
                we_d   = 1'b1;
                addr_d = cnt_q[ADDR_WIDTH-1:0];
                data_d = fill_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_w) begin
        if (rst) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            fill_q   <= '0;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign gnt         = gnt_q;
    assign mem_we      = we_q;
    assign mem_wr_addr = addr_q;
    assign mem_data_in = data_q;
    assign busy        = busy_q;
    assign init_done   = done_q;

endmodule

// File: tb/tb_ram_wr_sched.sv
// Directed bench for ram_wr_sched: grants, fairness, fill, collision, mid-fill reset.
module tb_ram_wr_sched;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NR = 4;

    logic             clk_w = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic             init_start;
    logic [DW-1:0]    init_value;
    logic             busy;
    logic             init_done;
    logic             mem_we;
    logic [AW-1:0]    mem_wr_addr;
    logic [DW-1:0]    mem_data_in;

    int n_vec = 0;
    int n_bad = 0;

    ram_wr_sched #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .clk_w       (clk_w),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .gnt         (gnt),
        .init_start  (init_start),
        .init_value  (init_value),
        .busy        (busy),
        .init_done   (init_done),
        .mem_we      (mem_we),
        .mem_wr_addr (mem_wr_addr),
        .mem_data_in (mem_data_in)
    );

    always #5 clk_w = ~clk_w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk_w);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt),         32'h0);
        chk({tag, "_we"},   32'(mem_we),      32'h0);
        chk({tag, "_addr"}, 32'(mem_wr_addr), 32'h0);
        chk({tag, "_data"}, 32'(mem_data_in), 32'h0);
        chk({tag, "_busy"}, 32'(busy),        32'h0);
        chk({tag, "_done"}, 32'(init_done),   32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_data   = '0;
        init_start = 1'b0;
        init_value = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Single requester on slot 2, held three edges.
        set_slot(0, 8'h01, 8'h11);
        set_slot(1, 8'h02, 8'h22);
        set_slot(2, 8'h10, 8'hA5);
        set_slot(3, 8'h04, 8'h44);
        req = 4'b0100;
        tick();
        chk("single_gnt1",  32'(gnt),         32'h4);
        chk("single_we1",   32'(mem_we),      32'h1);
        chk("single_addr1", 32'(mem_wr_addr), 32'h10);
        chk("single_data1", 32'(mem_data_in), 32'hA5);
        tick();
        chk("single_gnt2",  32'(gnt),         32'h0);
        chk("single_we2",   32'(mem_we),      32'h0);
        chk("single_hold_addr", 32'(mem_wr_addr), 32'h10);
        chk("single_hold_data", 32'(mem_data_in), 32'hA5);
        tick();
        chk("single_gnt3",  32'(gnt),         32'h4);
        chk("single_we3",   32'(mem_we),      32'h1);
        req = '0;
        tick();
        chk("single_gnt4",  32'(gnt),         32'h0);

        // Fairness from a freshly reset pointer: all four requesting continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_slot(0, 8'hA0, 8'h50);
        set_slot(1, 8'hA1, 8'h51);
        set_slot(2, 8'hA2, 8'h52);
        set_slot(3, 8'hA3, 8'h53);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_gnt",  32'(gnt),         32'(1 << (k % 4)));
            chk("rr_we",   32'(mem_we),      32'h1);
            chk("rr_addr", 32'(mem_wr_addr), 32'(8'hA0 + (k % 4)));
            chk("rr_data", 32'(mem_data_in), 32'(8'h50 + (k % 4)));
        end
        req = '0;
        tick();
        chk("rr_idle_we", 32'(mem_we), 32'h0);

        // Full fill with 0x3C; init_value changes after the start edge must not matter.
        init_start = 1'b1;
        init_value = 8'h3C;
        tick();
        init_start = 1'b0;
        init_value = 8'h00;
        chk("fill_start_we",   32'(mem_we), 32'h0);
        chk("fill_start_busy", 32'(busy),   32'h1);
        for (int a = 0; a < 256; a++) begin
            tick();
            chk("fill_we",   32'(mem_we),      32'h1);
            chk("fill_addr", 32'(mem_wr_addr), 32'(a));
            chk("fill_data", 32'(mem_data_in), 32'h3C);
            chk("fill_done", 32'(init_done),   32'(a == 255));
            chk("fill_busy", 32'(busy),        32'(a != 255));
        end
        tick();
        chk("fill_after_we",   32'(mem_we),    32'h0);
        chk("fill_after_done", 32'(init_done), 32'h0);
        chk("fill_after_busy", 32'(busy),      32'h0);

        // Collision: init_start beats req[0]; req[0] is served right after the fill.
        set_slot(0, 8'h77, 8'h5A);
        req        = 4'b0001;
        init_start = 1'b1;
        init_value = 8'hC3;
        tick();
        init_start = 1'b0;
        chk("coll_gnt",  32'(gnt),    32'h0);
        chk("coll_we",   32'(mem_we), 32'h0);
        chk("coll_busy", 32'(busy),   32'h1);
        for (int a = 0; a < 256; a++) begin
            tick();
            chk("coll_fill_gnt",  32'(gnt),         32'h0);
            chk("coll_fill_addr", 32'(mem_wr_addr), 32'(a));
            chk("coll_fill_data", 32'(mem_data_in), 32'hC3);
            chk("coll_fill_done", 32'(init_done),   32'(a == 255));
            // A restart attempt mid-fill is ignored.
            init_start = (a == 10);
            init_value = 8'hEE;
        end
        init_start = 1'b0;
        tick();
        chk("coll_gnt_after",  32'(gnt),         32'h1);
        chk("coll_we_after",   32'(mem_we),      32'h1);
        chk("coll_addr_after", 32'(mem_wr_addr), 32'h77);
        chk("coll_data_after", 32'(mem_data_in), 32'h5A);
        req = '0;
        tick();

        // Reset mid-fill at address 0x40, with init_start and req asserted alongside.
        init_start = 1'b1;
        init_value = 8'h99;
        tick();
        init_start = 1'b0;
        for (int a = 0; a <= 8'h40; a++) tick();
        chk("abort_at_addr", 32'(mem_wr_addr), 32'h40);
        chk("abort_at_data", 32'(mem_data_in), 32'h99);
        rst        = 1'b1;
        init_start = 1'b1;
        req        = 4'b0001;
        tick();
        rst        = 1'b0;
        init_start = 1'b0;
        req        = '0;
        chk_idle_outputs("abort");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 32'(init_done), 32'h0);
            chk("abort_no_we",   32'(mem_we),    32'h0);
        end

        // Fresh fill restarts from address 0.
        init_start = 1'b1;
        init_value = 8'h21;
        tick();
        init_start = 1'b0;
        chk("restart_busy", 32'(busy), 32'h1);
        tick();
        chk("restart_addr0", 32'(mem_wr_addr), 32'h00);
        chk("restart_data0", 32'(mem_data_in), 32'h21);
        chk("restart_we0",   32'(mem_we),      32'h1);
        tick();
        chk("restart_addr1", 32'(mem_wr_addr), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
